// File: rtl/vga_timing_pattern_gen.sv
// VGA raster timing generator with built-in test patterns (solid, colour bars,
// checkerboard, LFSR noise). All outputs are registered and aligned to x/y.
module vga_timing_pattern_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   BPC      = 2,
  parameter int   CLK_DIV  = 1,
  parameter int   CHK_LOG2 = 5,
  parameter int   CW       = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic [3*BPC-1:0] solid_color_i,
  output logic             hs_o,
  output logic             vs_o,
  output logic             active_o,
  output logic [CW-1:0]    x_o,
  output logic [CW-1:0]    y_o,
  output logic [3*BPC-1:0] rgb_o,
  output logic             frame_start_o,
  output logic [7:0]       frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_W    = CW'(H_ACTIVE / 8);

  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic             hs_q, hs_d, vs_q, vs_d, active_q, active_d;
  logic [3*BPC-1:0] rgb_q, rgb_d, pixel;
  logic             frameStart_q;
  logic [7:0]       frameCnt_q;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             pe, origin;
  logic [2:0]       barBits;

  // Everything is computed from the position the next pixel enable will land on,
  // so the registered colour/sync outputs line up with x/y on the same cycle.
  always_comb begin
    pe     = (div_q == DIV_LAST);
    div_d  = pe ? '0 : div_q + 1'b1;
    x_d    = x_q + 1'b1;
    y_d    = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
    origin   = (x_d == '0) && (y_d == '0);
    mode_d   = origin ? mode_i : mode_q;
    active_d = (x_d < H_ACT) && (y_d < V_ACT);
    hs_d     = (x_d >= HS_START && x_d < HS_END) ? HS_POL : ~HS_POL;
    vs_d     = (y_d >= VS_START && y_d < VS_END) ? VS_POL : ~VS_POL;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    barBits  = 3'd7 - 3'(x_d / BAR_W);
    pixel    = '0;
    case (mode_d)
      2'd0: pixel = solid_color_i;
      2'd1: pixel = {{BPC{barBits[2]}}, {BPC{barBits[1]}}, {BPC{barBits[0]}}};
      2'd2: pixel = (x_d[CHK_LOG2] ^ y_d[CHK_LOG2]) ? '0 : {(3*BPC){1'b1}};
      default: pixel = lfsr_q[3*BPC-1:0];
    endcase
    rgb_d = active_d ? pixel : '0;
  end

  // frame_start is a single-clk pulse even when pixels span several clks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q        <= '0;
      x_q          <= H_LAST;
      y_q          <= V_LAST;
      hs_q         <= ~HS_POL;
      vs_q         <= ~VS_POL;
      active_q     <= 1'b0;
      rgb_q        <= '0;
      frameStart_q <= 1'b0;
      frameCnt_q   <= 8'd0;
      mode_q       <= 2'd0;
      lfsr_q       <= 16'hACE1;
    end else begin
      div_q        <= div_d;
      frameStart_q <= 1'b0;
      if (pe) begin
        x_q          <= x_d;
        y_q          <= y_d;
        hs_q         <= hs_d;
        vs_q         <= vs_d;
        active_q     <= active_d;
        rgb_q        <= rgb_d;
        mode_q       <= mode_d;
        frameStart_q <= origin;
        if (origin) frameCnt_q <= frameCnt_q + 8'd1;
        if (active_d) lfsr_q <= lfsr_d;
      end
    end
  end

  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign active_o      = active_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign rgb_o         = rgb_q;
  assign frame_start_o = frameStart_q;
  assign frame_cnt_o   = frameCnt_q;

endmodule

// File: doc/vga_timing_pattern_gen.md
VGA_TIMING_PATTERN_GEN -- requirements
Module: vga_timing_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line; must be divisible by 8.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch/sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, vertical lines.
REQ-004 SHALL have parameters HS_POL, VS_POL, default 0, sync assertion level (0 = active-low).
REQ-005 SHALL have parameter BPC, 2, bits per colour channel.
REQ-006 SHALL have parameter CLK_DIV, 1, clk cycles per pixel (>=1).
REQ-007 SHALL have parameter CHK_LOG2, 5, log2 of the checkerboard cell size in pixels.
REQ-008 SHALL have parameter CW, 10, width of x/y; must hold H_TOTAL-1 and V_TOTAL-1.
REQ-009 clk  input  1  single clock; all state changes on rising edge.
REQ-010 rst  input  1  reset, synchronous, active-high.
REQ-011 mode  input  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 LFSR noise.
REQ-012 solid_color  input  3*BPC  {R,G,B} for mode 0.
REQ-013 hs, vs  output  1 each  horizontal/vertical sync.
REQ-014 active  output  1  current pixel is visible.
REQ-015 x, y  output  CW each  current column/row counters.
REQ-016 rgb  output  3*BPC  {R,G,B} pixel value.
REQ-017 frame_start  output  1  one-clk pulse when the position becomes (0,0).
REQ-018 frame_cnt  output  8  frame counter.

Function
REQ-019 H_TOTAL = sum of H params (800 default); V_TOTAL = sum of V params (525 default).
REQ-020 Pixel enable pe SHALL assert once every CLK_DIV clk cycles: divider counts 0..CLK_DIV-1, pe when count = CLK_DIV-1; continuous pe when CLK_DIV=1.
REQ-021 On pe: x increments; x = H_TOTAL-1 wraps to 0 and increments y; y = V_TOTAL-1 wraps to 0. All outputs hold between pes.
REQ-022 All outputs SHALL be registered, computed from the next position, and aligned with x/y (zero skew).
REQ-023 active = (x < H_ACTIVE) and (y < V_ACTIVE).
REQ-024 hs = HS_POL for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL; vs is the same on y with the V params.
REQ-025 Mode SHALL be sampled into mode_q only on the pe entering (0,0); mid-frame changes take effect at the next frame.
REQ-026 rgb = 0 whenever active = 0, regardless of mode.
REQ-027 Mode 0: rgb = solid_color. Colour changes are not latched and apply on the next pe.
REQ-028 Mode 1: bar k = x / (H_ACTIVE/8), k = 0..7; bits {r,g,b} = 7-k; each channel is all-ones if its bit is set, else zero.
REQ-029 Mode 2: white (all ones) if x[CHK_LOG2] XOR y[CHK_LOG2] = 0, else black.
REQ-030 Mode 3: rgb = lfsr[3*BPC-1:0]. The LFSR is 16-bit Galois, right shift; if the shifted-out lsb = 1, XOR 0xB400.
REQ-031 The LFSR SHALL step once per pe whose next position is active, in every mode. rgb uses the value before the step. It is never reseeded except by rst.
REQ-032 frame_start SHALL be high for exactly one clk cycle, coincident with outputs updating to (0,0).
REQ-033 frame_cnt SHALL increment with each frame_start and wrap 255 -> 0.

Reset
REQ-034 While rst = 1 on a clock edge: x = H_TOTAL-1, y = V_TOTAL-1, hs = ~HS_POL, vs = ~VS_POL, active = 0, rgb = 0, frame_start = 0, frame_cnt = 0, mode_q = 0, lfsr = 0xACE1, divider = 0.
REQ-035 rst asserted mid-frame SHALL override pe; the first pe after release enters (0,0) with frame_start = 1 and frame_cnt = 1.

Verification
REQ-036 Reset with defaults -> x=799, y=524, hs=vs=1, active=0, rgb=0; first cycle after release -> x=0, y=0, active=1, frame_start=1, frame_cnt=1.
REQ-037 Run one frame -> hs low exactly for x=656..751 each line; line period 800 clk; vs low for y=490..491 (1600 clk); frame period 420000 clk.
REQ-038 Mode 1, BPC=2 -> rgb=111111 for x=0..79, 111100 at x=80, 000000 at x=560..639; active=0 and rgb=0 at x=640.
REQ-039 Mode 0 -> 2 switched at y=100 -> solid rgb persists to frame end; next frame (0,0) rgb=111111, (32,0) rgb=000000, (32,32) rgb=111111.
REQ-040 Mode 3 from reset -> first pixel rgb=100001 (0xACE1), second pixel rgb=110000 (0xE270).
REQ-041 CLK_DIV=2, rst pulsed at x=300 -> outputs change only every 2nd clk; next cycle shows reset values; (0,0) and frame_start appear on the 2nd clk after release.
